// File: rtl/avalon_st_mon_pkg.sv
// Shared constants for the Avalon-ST RX statistics monitor: CSR map, CTRL bits,
// FSM states, statistic counter slots and the backpressure LFSR.
package avalon_st_mon_pkg;

    localparam logic [3:0] CSR_CTRL     = 4'd0;
    localparam logic [3:0] CSR_TARGET   = 4'd1;
    localparam logic [3:0] CSR_STATUS   = 4'd2;
    localparam logic [3:0] CSR_GOOD     = 4'd3;
    localparam logic [3:0] CSR_BAD      = 4'd4;
    localparam logic [3:0] CSR_RUNT     = 4'd5;
    localparam logic [3:0] CSR_OVERSIZE = 4'd6;
    localparam logic [3:0] CSR_FRAMING  = 4'd7;
    localparam logic [3:0] CSR_MAC_ERR  = 4'd8;
    localparam logic [3:0] CSR_BYTES_LO = 4'd9;
    localparam logic [3:0] CSR_BYTES_HI = 4'd10;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int CTRL_BP_EN = 3;

    // Counter slots follow the CSR order starting at CSR_GOOD.
    localparam int CNT_GOOD    = 0;
    localparam int CNT_BAD     = 1;
    localparam int CNT_RUNT    = 2;
    localparam int CNT_OVER    = 3;
    localparam int CNT_FRAMING = 4;
    localparam int CNT_MAC     = 5;
    localparam int CNT_N       = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } mon_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/avalon_st_rx_stats_mon_sat_counter.sv
// Saturating accumulator: adds amt when inc is set, sticks at all-ones, clr wins.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] amt,
    output logic [W-1:0] q
);

    logic [W:0] sum;

    assign sum = {1'b0, q} + {1'b0, amt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= sum[W] ? '1 : sum[W-1:0];
    end

endmodule

// File: rtl/avalon_st_rx_stats_mon.sv
// Avalon-ST RX packet monitor: checks framing and length of accepted beats,
// keeps saturating statistics and exposes them through an Avalon-MM CSR block.
module avalon_st_rx_stats_mon
    import avalon_st_mon_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int ERR_W   = 6,
    parameter int CNT_W   = 32,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         avalon_mm_address,
    input  logic               avalon_mm_write,
    input  logic [31:0]        avalon_mm_writedata,
    input  logic               avalon_mm_read,
    output logic [31:0]        avalon_mm_readdata,
    input  logic [DATA_W-1:0]  avalon_st_rx_data,
    input  logic               avalon_st_rx_valid,
    input  logic               avalon_st_rx_sop,
    input  logic               avalon_st_rx_eop,
    input  logic [EMPTY_W-1:0] avalon_st_rx_empty,
    input  logic [ERR_W-1:0]   avalon_st_rx_error,
    output logic               avalon_st_rx_ready,
    input  logic               mac_rx_status_valid,
    input  logic               mac_rx_status_error,
    input  logic               stop_mon,
    output logic               mon_active,
    output logic               mon_done,
    output logic               mon_error
);

    localparam int BPB = DATA_W / 8;
    localparam int LEN_W = $clog2(MAX_LEN + 2) + 1;
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    mon_state_e                   state;
    logic [15:0]                  lfsr;
    logic                         bp_en;
    logic [31:0]                  target;
    logic                         in_pkt;
    logic [LEN_W-1:0]             len, beat_bytes, sum_len, new_len;
    logic                         ctrl_wr, start_p, stop_p, clr_p, acc;
    logic                         abort, pkt_end, stray, runt, over, pkt_bad, pkt_good;
    logic                         tgt_hit, set_err;
    logic [CNT_W+1:0]             total_after;
    logic [CNT_N-1:0]             cnt_inc;
    logic [CNT_N-1:0][CNT_W-1:0]  cnt_amt, cnt_q;
    logic [2*CNT_W-1:0]           bytes_q;
    logic [31:0]                  rd_mux;
    logic                         unused_data;

    assign unused_data = ^avalon_st_rx_data;

    assign ctrl_wr = avalon_mm_write & (avalon_mm_address == CSR_CTRL);
    assign start_p = ctrl_wr & avalon_mm_writedata[CTRL_START];
    assign stop_p  = ctrl_wr & avalon_mm_writedata[CTRL_STOP];
    assign clr_p   = ctrl_wr & avalon_mm_writedata[CTRL_CLEAR];

    assign avalon_st_rx_ready = (state == ST_ACTIVE) & (~bp_en | lfsr[0]);
    assign acc = avalon_st_rx_valid & avalon_st_rx_ready;

    assign beat_bytes = avalon_st_rx_eop ? LEN_W'(BPB) - LEN_W'(avalon_st_rx_empty) : LEN_W'(BPB);
    assign sum_len    = (avalon_st_rx_sop ? '0 : len) + beat_bytes;
    assign new_len    = (sum_len > LEN_SAT) ? LEN_SAT : sum_len;

    // A SOP inside a packet aborts the old one; non-SOP beats outside a packet are strays.
    always_comb begin
        abort   = 1'b0;
        pkt_end = 1'b0;
        stray   = 1'b0;
        if (acc) begin
            if (avalon_st_rx_sop) begin
                abort   = in_pkt;
                pkt_end = avalon_st_rx_eop;
            end else if (in_pkt) begin
                pkt_end = avalon_st_rx_eop;
            end else begin
                stray = 1'b1;
            end
        end
    end

    assign runt     = pkt_end & (new_len < LEN_W'(MIN_LEN));
    assign over     = pkt_end & (new_len > LEN_W'(MAX_LEN));
    assign pkt_bad  = pkt_end & ((|avalon_st_rx_error) | runt | over);
    assign pkt_good = pkt_end & ~pkt_bad;

    always_comb begin
        cnt_inc = '0;
        for (int i = 0; i < CNT_N; i++)
            cnt_amt[i] = CNT_W'(1);
        cnt_inc[CNT_GOOD]    = pkt_good;
        cnt_inc[CNT_BAD]     = abort | pkt_bad;
        cnt_amt[CNT_BAD]     = CNT_W'(abort) + CNT_W'(pkt_bad);
        cnt_inc[CNT_RUNT]    = runt;
        cnt_inc[CNT_OVER]    = over;
        cnt_inc[CNT_FRAMING] = abort | stray;
        cnt_inc[CNT_MAC]     = mac_rx_status_valid & mac_rx_status_error;
    end

    assign set_err = cnt_inc[CNT_BAD] | cnt_inc[CNT_FRAMING] | cnt_inc[CNT_MAC];

    for (genvar g = 0; g < CNT_N; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_p),
            .inc   (cnt_inc[g]),
            .amt   (cnt_amt[g]),
            .q     (cnt_q[g])
        );
    end

    sat_counter #(.W(2 * CNT_W)) u_bytes (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_p),
        .inc   (pkt_good),
        .amt   ((2 * CNT_W)'(new_len)),
        .q     (bytes_q)
    );

    // Target is judged on post-increment totals so DONE lands on the packet end itself.
    assign total_after = (CNT_W + 2)'(cnt_q[CNT_GOOD]) + (CNT_W + 2)'(cnt_q[CNT_BAD])
                       + (CNT_W + 2)'(pkt_good) + (CNT_W + 2)'(abort) + (CNT_W + 2)'(pkt_bad);
    assign tgt_hit = (target != '0) & (abort | pkt_end) & (64'(total_after) >= 64'(target));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mon_active <= 1'b0;
            mon_done   <= 1'b0;
            in_pkt     <= 1'b0;
            len        <= '0;
        end else begin
            if (acc && (avalon_st_rx_sop || in_pkt)) begin
                len    <= new_len;
                in_pkt <= ~avalon_st_rx_eop;
            end
            case (state)
                ST_IDLE, ST_DONE: if (start_p) begin
                    state      <= ST_ACTIVE;
                    mon_active <= 1'b1;
                    mon_done   <= 1'b0;
                end
                ST_ACTIVE: if (stop_p || stop_mon || tgt_hit) begin
                    state      <= ST_DONE;
                    mon_active <= 1'b0;
                    mon_done   <= 1'b1;
                    in_pkt     <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    mon_active <= 1'b0;
                    mon_done   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avalon_mm_address)
            CSR_TARGET:   rd_mux = target;
            CSR_STATUS:   rd_mux = {29'd0, mon_error, mon_done, mon_active};
            CSR_GOOD, CSR_BAD, CSR_RUNT, CSR_OVERSIZE, CSR_FRAMING, CSR_MAC_ERR:
                          rd_mux = 32'(cnt_q[3'(avalon_mm_address - CSR_GOOD)]);
            CSR_BYTES_LO: rd_mux = 32'(bytes_q);
            CSR_BYTES_HI: rd_mux = 32'(bytes_q >> 32);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr               <= LFSR_SEED;
            bp_en              <= 1'b0;
            target             <= '0;
            mon_error          <= 1'b0;
            avalon_mm_readdata <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            if (ctrl_wr)
                bp_en <= avalon_mm_writedata[CTRL_BP_EN];
            if (avalon_mm_write && avalon_mm_address == CSR_TARGET)
                target <= avalon_mm_writedata;
            if (clr_p)
                mon_error <= 1'b0;
            else if (set_err)
                mon_error <= 1'b1;
            if (avalon_mm_read)
                avalon_mm_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_st_rx_stats_mon.sv
// Randomised scoreboard bench for avalon_st_rx_stats_mon: CSR reads are checked
// against a frame-level reference model of the monitor's statistics.
module tb_avalon_st_rx_stats_mon;

    localparam int DATA_W = 64;
    localparam int BPB    = DATA_W / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  avalon_mm_address = '0;
    logic        avalon_mm_write = 1'b0;
    logic [31:0] avalon_mm_writedata = '0;
    logic        avalon_mm_read = 1'b0;
    logic [31:0] avalon_mm_readdata;
    logic [DATA_W-1:0] avalon_st_rx_data = '0;
    logic        avalon_st_rx_valid = 1'b0;
    logic        avalon_st_rx_sop = 1'b0;
    logic        avalon_st_rx_eop = 1'b0;
    logic [2:0]  avalon_st_rx_empty = '0;
    logic [5:0]  avalon_st_rx_error = '0;
    logic        avalon_st_rx_ready;
    logic        mac_rx_status_valid = 1'b0;
    logic        mac_rx_status_error = 1'b0;
    logic        stop_mon = 1'b0;
    logic        mon_active, mon_done, mon_error;

    avalon_st_rx_stats_mon dut (
        .clk(clk), .reset(reset),
        .avalon_mm_address(avalon_mm_address), .avalon_mm_write(avalon_mm_write),
        .avalon_mm_writedata(avalon_mm_writedata), .avalon_mm_read(avalon_mm_read),
        .avalon_mm_readdata(avalon_mm_readdata),
        .avalon_st_rx_data(avalon_st_rx_data), .avalon_st_rx_valid(avalon_st_rx_valid),
        .avalon_st_rx_sop(avalon_st_rx_sop), .avalon_st_rx_eop(avalon_st_rx_eop),
        .avalon_st_rx_empty(avalon_st_rx_empty), .avalon_st_rx_error(avalon_st_rx_error),
        .avalon_st_rx_ready(avalon_st_rx_ready),
        .mac_rx_status_valid(mac_rx_status_valid), .mac_rx_status_error(mac_rx_status_error),
        .stop_mon(stop_mon), .mon_active(mon_active), .mon_done(mon_done), .mon_error(mon_error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;

    // Reference model state (0 idle, 1 active, 2 done)
    int unsigned     m_good, m_bad, m_runt, m_over, m_fram, m_mac, m_target;
    longint unsigned m_bytes;
    bit              m_err, m_bp;
    int              m_state;
    logic [15:0]     m_lfsr;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_pend;
    bit          chk_rdy = 1'b0;
    bit          mac_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
        return (l >> 1) | (b << 15);
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);

    always @(posedge clk or posedge reset)
        if (reset) rd_pend <= 1'b0;
        else       rd_pend <= avalon_mm_read;

    // Scoreboard monitor: one expected value per completed read
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_read: got 0x%0h expected no read", avalon_mm_readdata);
            end else begin
                logic [31:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, avalon_mm_readdata, e);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_rdy)
            chk("ready_lfsr", {31'd0, avalon_st_rx_ready},
                {31'd0, (m_state == 1) && (!m_bp || m_lfsr[0])});
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mac_en) begin
                mac_rx_status_valid = ($urandom_range(0, 7) == 0);
                mac_rx_status_error = 1'($urandom_range(0, 1));
                if (mac_rx_status_valid && mac_rx_status_error) begin
                    m_mac++;
                    m_err = 1'b1;
                end
            end else begin
                mac_rx_status_valid = 1'b0;
                mac_rx_status_error = 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_csr(input int a);
        case (a)
            1:  return m_target;
            2:  return {29'd0, m_err, m_state == 2, m_state == 1};
            3:  return m_good;
            4:  return m_bad;
            5:  return m_runt;
            6:  return m_over;
            7:  return m_fram;
            8:  return m_mac;
            9:  return m_bytes[31:0];
            10: return m_bytes[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_good = 0; m_bad = 0; m_runt = 0; m_over = 0; m_fram = 0; m_mac = 0;
        m_bytes = 0; m_err = 1'b0;
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        avalon_mm_address = a; avalon_mm_writedata = d; avalon_mm_write = 1'b1;
        @(negedge clk);
        avalon_mm_write = 1'b0;
    endtask

    task automatic csr_read(input int a);
        avalon_mm_address = 4'(a); avalon_mm_read = 1'b1;
        exp_q.push_back(exp_csr(a));
        name_q.push_back($sformatf("csr[%0d]", a));
        @(negedge clk);
        avalon_mm_read = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) csr_read(a);
    endtask

    task automatic ctrl(input bit start, input bit stop, input bit clr, input bit bp);
        m_bp = bp;
        if (clr) model_reset();
        if (start && m_state != 1) m_state = 1;
        else if (stop && m_state == 1) m_state = 2;
        csr_write(4'd0, {28'd0, bp, clr, stop, start});
    endtask

    task automatic send_beat(input bit sop, input bit eop, input int empty,
                             input logic [5:0] err, input int maxw, output bit ok);
        int n = 0;
        avalon_st_rx_valid = 1'b1;
        avalon_st_rx_sop   = sop;
        avalon_st_rx_eop   = eop;
        avalon_st_rx_empty = 3'(empty);
        avalon_st_rx_error = eop ? err : 6'd0;
        avalon_st_rx_data  = {$urandom, $urandom};
        while (!avalon_st_rx_ready && n < maxw) begin
            @(negedge clk);
            n++;
        end
        ok = avalon_st_rx_ready;
        @(negedge clk);
        avalon_st_rx_valid = 1'b0; avalon_st_rx_sop = 1'b0; avalon_st_rx_eop = 1'b0;
        avalon_st_rx_empty = '0;   avalon_st_rx_error = '0;
    endtask

    task automatic send_frame(input int len, input logic [5:0] err, input int maxw, output bit ok);
        int nb = (len + BPB - 1) / BPB;
        ok = 1'b1;
        for (int i = 0; i < nb && ok; i++)
            send_beat(i == 0, i == nb - 1, (i == nb - 1) ? nb * BPB - len : 0, err, maxw, ok);
    endtask

    task automatic model_pkt(input int len, input logic [5:0] err);
        bit badp;
        badp = (err != 0) || (len < 64) || (len > 1518);
        if (len < 64)   m_runt++;
        if (len > 1518) m_over++;
        if (badp) begin m_bad++; m_err = 1'b1; end
        else begin m_good++; m_bytes += longint'(len); end
        if (m_target != 0 && m_good + m_bad >= m_target) m_state = 2;
    endtask

    task automatic frame(input int len, input logic [5:0] err);
        bit ok, exp_ok;
        exp_ok = (m_state == 1);
        send_frame(len, err, exp_ok ? 64 : 16, ok);
        chk(exp_ok ? "frame_accepted" : "frame_blocked", {31'd0, ok}, {31'd0, exp_ok});
        if (exp_ok) model_pkt(len, err);
    endtask

    initial begin
        bit ok;
        int w;
        model_reset();
        m_state = 0; m_target = 0; m_bp = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, avalon_st_rx_ready}, 32'd0);
        chk("reset_flags", {29'd0, mon_error, mon_done, mon_active}, 32'd0);
        chk("reset_readdata", avalon_mm_readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        read_all();

        // 1: ten good 64B frames
        ctrl(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) frame(64, 6'd0);
        read_all();

        // 2: target of five stops the monitor after frame five
        ctrl(0, 0, 1, 0);
        csr_write(4'd1, 32'd5); m_target = 5;
        for (int i = 0; i < 8; i++) frame(64, 6'd0);
        chk("ready_after_done", {31'd0, avalon_st_rx_ready}, 32'd0);
        read_all();
        csr_write(4'd1, 32'd0); m_target = 0;
        ctrl(1, 0, 0, 0);

        // 3: runt, oversize, errored frame
        ctrl(0, 0, 1, 0);
        frame(60, 6'd0);
        frame(1600, 6'd0);
        frame(100, 6'h01);
        read_all();

        // 4: dangling SOP, full frame, stray EOP
        ctrl(0, 0, 1, 0);
        send_beat(1, 0, 0, 6'd0, 16, ok);
        chk("t4_beat", {31'd0, ok}, 32'd1);
        frame(64, 6'd0);
        m_good = 0; m_bad = 0; m_bytes = 0;
        m_good = 1; m_bad = 1; m_fram = 2; m_bytes = 64; m_err = 1'b1;
        send_beat(0, 1, 0, 6'd0, 16, ok);
        chk("t4_stray", {31'd0, ok}, 32'd1);
        read_all();

        // 5: random frames under LFSR backpressure, with MAC status noise
        ctrl(0, 0, 1, 1);
        chk_rdy = 1'b1;
        mac_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int len;
            logic [5:0] err;
            len = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1500, 1540))
                                               : int'($urandom_range(20, 160));
            err = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            frame(len, err);
        end
        mac_en = 1'b0;
        chk_rdy = 1'b0;
        repeat (3) @(negedge clk);
        read_all();
        ctrl(0, 0, 0, 0);

        // 6: stop mid-frame, clear on EOP, reset mid-frame
        ctrl(0, 0, 1, 0);
        send_beat(1, 0, 0, 6'd0, 16, ok);
        send_beat(0, 0, 0, 6'd0, 16, ok);
        send_beat(0, 0, 0, 6'd0, 16, ok);
        stop_mon = 1'b1;
        @(negedge clk);
        stop_mon = 1'b0;
        m_state = 2;
        read_all();
        ctrl(1, 0, 0, 0);
        frame(64, 6'd0);
        read_all();
        for (int i = 0; i < 7; i++) send_beat(i == 0, 0, 0, 6'd0, 16, ok);
        avalon_st_rx_valid = 1'b1; avalon_st_rx_eop = 1'b1;
        avalon_mm_address = 4'd0; avalon_mm_writedata = 32'h4; avalon_mm_write = 1'b1;
        model_reset();
        @(negedge clk);
        avalon_st_rx_valid = 1'b0; avalon_st_rx_eop = 1'b0; avalon_mm_write = 1'b0;
        read_all();
        send_beat(1, 0, 0, 6'd0, 16, ok);
        send_beat(0, 0, 0, 6'd0, 16, ok);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_ready", {31'd0, avalon_st_rx_ready}, 32'd0);
        chk("async_reset_flags", {29'd0, mon_error, mon_done, mon_active}, 32'd0);
        chk("async_reset_readdata", avalon_mm_readdata, 32'd0);
        model_reset();
        m_state = 0; m_target = 0; m_bp = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_all();
        ctrl(1, 0, 0, 0);
        send_beat(0, 1, 0, 6'd0, 16, ok);
        m_fram = 1; m_err = 1'b1;
        read_all();

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_total++; n_bad++;
            $display("FAIL read_drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
